// File: rtl/tone_detector_if.sv
// Tone detector bus: the raw buzzer tone going in and the decoded note coming out.
// The master drives the tone, and the slave is the detector that decodes it.
interface tone_detector_if;
    logic        tone_in;
    logic [3:0]  note;
    logic [1:0]  octave;
    logic        valid;
    logic        note_strobe;
    logic [20:0] period;

    modport master (
        output tone_in,
        input  note, octave, valid, note_strobe, period
    );

    modport slave (
        input  tone_in,
        output note, octave, valid, note_strobe, period
    );
endinterface

// File: rtl/tone_detector.sv
// Tone detector: measures the half-period of a square-wave buzzer tone and
// decodes it into one of seven notes in three octaves. A note is accepted only
// after two consecutive matching measurements, so a single stray period cannot
// drop or change the lock. Long silence unlocks the detector.
// NOMINAL_STD packs the seven standard half-periods with do in the low 21 bits.
module tone_detector #(
    parameter int unsigned  TIMEOUT     = 1048575,
    parameter int unsigned  TOL_SHIFT   = 6,
    parameter logic [146:0] NOMINAL_STD = {21'd202430, 21'd227274, 21'd255103,
                                           21'd285715, 21'd303031, 21'd340137,
                                           21'd381681}
) (
    input logic            clk,
    input logic            rst,
    tone_detector_if.slave io_bus
);

    typedef enum logic [1:0] {SILENT, ARMED, LOCKED} state_t;

    localparam logic [20:0] TIMEOUT_CNT = 21'(TIMEOUT);
    localparam logic [20:0] TIMEOUT_PRE = 21'(TIMEOUT - 1);

    logic        r_sync1, r_sync2, r_syncPrev, r_edge;
    logic [20:0] r_cnt;
    state_t      r_state, w_stateNext;
    logic [5:0]  r_candidate, w_candidateNext;
    logic [3:0]  r_note, w_noteNext;
    logic [1:0]  r_octave, w_octaveNext;
    logic        r_valid, w_validNext;
    logic        r_strobe, w_strobeNext;
    logic [20:0] r_period, w_periodNext;

    logic [21:0] w_p;
    logic [5:0]  w_class;
    logic [5:0]  w_outClass;
    logic        w_timeout;

    // Maps a measured half-period to {octave, note}; 0 means no window matched.
    // Octave index 0/1/2 equals the output encoding 00/01/10 (standard/higher/lower).
    function automatic logic [5:0] classify(input logic [21:0] p);
        logic [5:0]  cls;
        logic [21:0] nom;
        logic [21:0] tol;
        cls = '0;
        for (int n = 0; n < 7; n++) begin
            for (int o = 0; o < 3; o++) begin
                nom = {1'b0, NOMINAL_STD[n*21 +: 21]};
                if (o == 1) begin
                    nom = nom >> 1;
                end else if (o == 2) begin
                    nom = nom << 1;
                end
                tol = nom >> TOL_SHIFT;
                if ((p <= nom + tol) && (p + tol >= nom)) begin
                    cls = {2'(o), 4'(n + 1)};
                end
            end
        end
        return cls;
    endfunction

    // Two-flop synchronizer on the tone, then a registered edge pulse on any level change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_syncPrev <= 1'b0;
            r_edge     <= 1'b0;
        end else begin
            r_sync1    <= io_bus.tone_in;
            r_sync2    <= r_sync1;
            r_syncPrev <= r_sync2;
            r_edge     <= r_sync2 ^ r_syncPrev;
        end
    end

    // Cycles since the last edge, saturating so silence never wraps into a false period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_edge) begin
            r_cnt <= '0;
        end else if (r_cnt < TIMEOUT_CNT) begin
            r_cnt <= r_cnt + 21'd1;
        end
    end

    assign w_p        = {1'b0, r_cnt} + 22'd1;
    assign w_class    = classify(w_p);
    assign w_outClass = {r_octave, r_note};
    assign w_timeout  = !r_edge && (r_cnt >= TIMEOUT_PRE);

    // State and output registers; everything the outside world sees is registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= SILENT;
            r_candidate <= '0;
            r_note      <= '0;
            r_octave    <= '0;
            r_valid     <= 1'b0;
            r_strobe    <= 1'b0;
            r_period    <= '0;
        end else begin
            r_state     <= w_stateNext;
            r_candidate <= w_candidateNext;
            r_note      <= w_noteNext;
            r_octave    <= w_octaveNext;
            r_valid     <= w_validNext;
            r_strobe    <= w_strobeNext;
            r_period    <= w_periodNext;
        end
    end

    // Lock logic: an edge always wins over a timeout in the same cycle, and a
    // class must be seen twice in a row before it reaches the outputs.
    always_comb begin
        w_stateNext     = r_state;
        w_candidateNext = r_candidate;
        w_noteNext      = r_note;
        w_octaveNext    = r_octave;
        w_validNext     = r_valid;
        w_strobeNext    = 1'b0;
        w_periodNext    = r_period;
        if (r_edge) begin
            case (r_state)
                SILENT: begin
                    w_stateNext     = ARMED;
                    w_candidateNext = '0;
                end
                ARMED: begin
                    w_periodNext = w_p[20:0];
                    if (w_class != 6'd0 && w_class == r_candidate) begin
                        w_stateNext  = LOCKED;
                        w_noteNext   = w_class[3:0];
                        w_octaveNext = w_class[5:4];
                        w_validNext  = 1'b1;
                        w_strobeNext = 1'b1;
                    end
                    w_candidateNext = w_class;
                end
                LOCKED: begin
                    w_periodNext = w_p[20:0];
                    if (w_class != w_outClass && w_class != 6'd0 && w_class == r_candidate) begin
                        w_noteNext   = w_class[3:0];
                        w_octaveNext = w_class[5:4];
                        w_strobeNext = 1'b1;
                    end
                    w_candidateNext = w_class;
                end
                default: begin
                    w_stateNext     = SILENT;
                    w_candidateNext = '0;
                end
            endcase
        end else if (w_timeout) begin
            w_stateNext     = SILENT;
            w_candidateNext = '0;
            w_noteNext      = '0;
            w_octaveNext    = '0;
            w_validNext     = 1'b0;
            w_strobeNext    = r_valid;
        end
    end

    assign io_bus.note        = r_note;
    assign io_bus.octave      = r_octave;
    assign io_bus.valid       = r_valid;
    assign io_bus.note_strobe = r_strobe;
    assign io_bus.period      = r_period;

endmodule

// File: tb/tb_tone_detector.sv
// Bench for tone_detector. The nominal table is scaled down by 256 (rounded),
// and TIMEOUT is shortened so that every scenario fits in a short run.
// Expected strobes, each with the exact cycle it must appear on, go into a
// queue when the tone edge is driven. The monitor pops them when the DUT strobes.
module tb_tone_detector;

    localparam int TIMEOUT_TB = 4000;
    // Standard half-periods: si la so fa mi re do (do in the low bits).
    localparam logic [146:0] NOMINAL_TB = {21'd791, 21'd888, 21'd996, 21'd1116,
                                           21'd1184, 21'd1329, 21'd1491};

    typedef struct {
        logic [3:0] note;
        logic [1:0] octave;
        logic       valid;
        int         atCycle;
    } strobe_t;

    typedef struct {
        string      name;
        int         halfPeriod;
        int         edges;
        logic       expValid;
        logic [3:0] expNote;
        logic [1:0] expOct;
    } vec_t;

    logic    clk = 1'b0;
    logic    rst;
    int      cycle = 0;
    int      checks = 0;
    int      errors = 0;
    int      lastToggleCycle = 0;
    logic    prevStrobe = 1'b0;
    strobe_t expQ[$];
    strobe_t mon;
    vec_t    vecs[9];

    tone_detector_if io();

    tone_detector #(
        .TIMEOUT    (TIMEOUT_TB),
        .TOL_SHIFT  (6),
        .NOMINAL_STD(NOMINAL_TB)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .io_bus(io)
    );

    always #5 clk = ~clk;

    // Free-running cycle count, used to pin the expected strobe timing.
    always @(posedge clk) cycle <= cycle + 1;

    function automatic void checkOutput(string name, int actual, int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endfunction

    function automatic vec_t makeVec(string name, int hp, int edges, logic v,
                                     logic [3:0] n, logic [1:0] o);
        vec_t r;
        r.name       = name;
        r.halfPeriod = hp;
        r.edges      = edges;
        r.expValid   = v;
        r.expNote    = n;
        r.expOct     = o;
        return r;
    endfunction

    task automatic pushExpect(logic [3:0] n, logic [1:0] o, logic v, int at);
        strobe_t e;
        e.note    = n;
        e.octave  = o;
        e.valid   = v;
        e.atCycle = at;
        expQ.push_back(e);
    endtask

    // Every strobe must be expected, land on its exact cycle, and never be back to back.
    always @(negedge clk) begin
        if (io.note_strobe === 1'b1) begin
            checkOutput("strobe_gap", int'(prevStrobe), 0);
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_strobe: got note_strobe=1 at cycle %0d, expected none", cycle);
            end else begin
                mon = expQ.pop_front();
                checkOutput("strobe_cycle", cycle, mon.atCycle);
                checkOutput("strobe_note", int'(io.note), int'(mon.note));
                checkOutput("strobe_octave", int'(io.octave), int'(mon.octave));
                checkOutput("strobe_valid", int'(io.valid), int'(mon.valid));
            end
        end
        prevStrobe <= io.note_strobe;
    end

    // Toggle the tone on a falling edge; it is sampled on the next rising edge.
    task automatic toneEdge(output int sampleCycle);
        @(negedge clk);
        io.tone_in = ~io.tone_in;
        lastToggleCycle = cycle;
        sampleCycle = cycle + 1;
    endtask

    // Next toggle exactly 'half' clocks after the previous one.
    task automatic playHalf(input int half, output int sampleCycle);
        while (cycle < lastToggleCycle + half - 1) @(negedge clk);
        toneEdge(sampleCycle);
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst = 1'b1;
        io.tone_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic applyStimulus(input vec_t v);
        int s;
        applyReset();
        toneEdge(s);
        for (int e = 1; e < v.edges; e++) playHalf(v.halfPeriod, s);
        if (v.expValid) pushExpect(v.expNote, v.expOct, 1'b1, s + 3);
        repeat (6) @(negedge clk);
        checkOutput({v.name, "_valid"}, int'(io.valid), int'(v.expValid));
        checkOutput({v.name, "_note"}, int'(io.note), int'(v.expNote));
        checkOutput({v.name, "_octave"}, int'(io.octave), int'(v.expOct));
        checkOutput({v.name, "_period"}, int'(io.period), v.halfPeriod);
        checkOutput({v.name, "_drained"}, expQ.size(), 0);
    endtask

    initial begin
        int s;

        vecs[0] = makeVec("do_std",      1491, 3, 1'b1, 4'd1, 2'b00);
        vecs[1] = makeVec("la_high",      444, 3, 1'b1, 4'd6, 2'b01);
        vecs[2] = makeVec("si_low",      1582, 3, 1'b1, 4'd7, 2'b10);
        vecs[3] = makeVec("mi_std",      1184, 3, 1'b1, 4'd3, 2'b00);
        vecs[4] = makeVec("do_high",      745, 3, 1'b1, 4'd1, 2'b01);
        vecs[5] = makeVec("re_std_hi",   1349, 3, 1'b1, 4'd2, 2'b00);
        vecs[6] = makeVec("so_high_lo",   491, 3, 1'b1, 4'd5, 2'b01);
        vecs[7] = makeVec("re_std_out",  1350, 4, 1'b0, 4'd0, 2'b00);
        vecs[8] = makeVec("gap_re_mi",   1289, 4, 1'b0, 4'd0, 2'b00);

        rst = 1'b1;
        io.tone_in = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_note", int'(io.note), 0);
        checkOutput("rst_octave", int'(io.octave), 0);
        checkOutput("rst_valid", int'(io.valid), 0);
        checkOutput("rst_strobe", int'(io.note_strobe), 0);
        checkOutput("rst_period", int'(io.period), 0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) applyStimulus(vecs[i]);

        // A stray mi inside a re lock is ignored; two mi in a row move the lock.
        applyReset();
        toneEdge(s);
        playHalf(1329, s);
        playHalf(1329, s);
        pushExpect(4'd2, 2'b00, 1'b1, s + 3);
        playHalf(1184, s);
        playHalf(1329, s);
        repeat (6) @(negedge clk);
        checkOutput("stray_note", int'(io.note), 2);
        checkOutput("stray_valid", int'(io.valid), 1);
        playHalf(1329, s);
        playHalf(1184, s);
        playHalf(1184, s);
        pushExpect(4'd3, 2'b00, 1'b1, s + 3);
        repeat (6) @(negedge clk);
        checkOutput("move_note", int'(io.note), 3);
        checkOutput("move_drained", expQ.size(), 0);

        // Hold the tone: exactly TIMEOUT cycles after the last edge took effect, unlock.
        pushExpect(4'd0, 2'b00, 1'b0, s + 3 + TIMEOUT_TB);
        repeat (TIMEOUT_TB + 10) @(negedge clk);
        checkOutput("timeout_valid", int'(io.valid), 0);
        checkOutput("timeout_note", int'(io.note), 0);
        checkOutput("timeout_drained", expQ.size(), 0);

        // Reset during a so lock clears at once without a strobe, then relocks.
        applyReset();
        toneEdge(s);
        playHalf(996, s);
        playHalf(996, s);
        pushExpect(4'd5, 2'b00, 1'b1, s + 3);
        playHalf(996, s);
        repeat (400) @(negedge clk);
        checkOutput("so_locked_note", int'(io.note), 5);
        rst = 1'b1;
        #1;
        checkOutput("midrst_valid", int'(io.valid), 0);
        checkOutput("midrst_note", int'(io.note), 0);
        checkOutput("midrst_strobe", int'(io.note_strobe), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        playHalf(996, s);
        playHalf(996, s);
        playHalf(996, s);
        pushExpect(4'd5, 2'b00, 1'b1, s + 3);
        repeat (6) @(negedge clk);
        checkOutput("relock_note", int'(io.note), 5);
        checkOutput("relock_valid", int'(io.valid), 1);
        checkOutput("relock_drained", expQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
